// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S data path: instruction decode enum,
// ALU select encoding, opcode values, IR field positions and multiplier FSM states.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNEG   = 4'd10,
    I_BOV    = 4'd11,
    I_BNOV   = 4'd12,
    I_HALT   = 4'd13,
    I_MUL    = 4'd14
  } decoded_instruction_type;

  typedef enum logic [2:0] {
    ALU_OR     = 3'b000,
    ALU_ADD    = 3'b001,
    ALU_SUB    = 3'b010,
    ALU_AND    = 3'b011,
    ALU_MUL    = 3'b100,
    ALU_PASS_A = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_LOAD   = 4'h1;
  localparam logic [3:0] OPC_STORE  = 4'h2;
  localparam logic [3:0] OPC_MOVE   = 4'h3;
  localparam logic [3:0] OPC_ADD    = 4'h4;
  localparam logic [3:0] OPC_SUB    = 4'h5;
  localparam logic [3:0] OPC_AND    = 4'h6;
  localparam logic [3:0] OPC_OR     = 4'h7;
  localparam logic [3:0] OPC_BRANCH = 4'h8;
  localparam logic [3:0] OPC_BZERO  = 4'h9;
  localparam logic [3:0] OPC_BNEG   = 4'hA;
  localparam logic [3:0] OPC_BOV    = 4'hB;
  localparam logic [3:0] OPC_BNOV   = 4'hC;
  localparam logic [3:0] OPC_HALT   = 4'hD;
  localparam logic [3:0] OPC_MUL    = 4'hE;

  localparam int IR_OPC_LSB = 12;
  localparam int IR_C_LSB   = 8;
  localparam int IR_A_LSB   = 4;
  localparam int IR_B_LSB   = 0;

  function automatic decoded_instruction_type decode_opcode(input logic [3:0] opc,
                                                            input logic mul_en);
    decoded_instruction_type d;
    d = I_NOP;
    case (opc)
      OPC_LOAD:   d = I_LOAD;
      OPC_STORE:  d = I_STORE;
      OPC_MOVE:   d = I_MOVE;
      OPC_ADD:    d = I_ADD;
      OPC_SUB:    d = I_SUB;
      OPC_AND:    d = I_AND;
      OPC_OR:     d = I_OR;
      OPC_BRANCH: d = I_BRANCH;
      OPC_BZERO:  d = I_BZERO;
      OPC_BNEG:   d = I_BNEG;
      OPC_BOV:    d = I_BOV;
      OPC_BNOV:   d = I_BNOV;
      OPC_HALT:   d = I_HALT;
      OPC_MUL:    d = mul_en ? I_MUL : I_NOP;
      default:    d = I_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Unsigned shift-add multiplier: one partial product per cycle for DATA_W cycles,
// then a single DONE cycle. product_next/last let the owner commit on the final RUN edge.
module mul_iter
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  idle,
  output logic                  busy,
  output logic                  done,
  output logic                  last,
  output logic [2*DATA_W-1:0]   product_next,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W);

  mul_state_e           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*DATA_W-1:0]  mcand;
  logic [DATA_W-1:0]    mplier;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MUL_IDLE;
      cnt     <= '0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      state <= state_nxt;
      if (state == MUL_IDLE && start) begin
        product <= '0;
        mcand   <= {{DATA_W{1'b0}}, a};
        mplier  <= b;
        cnt     <= '0;
      end else if (state == MUL_RUN) begin
        product <= product_next;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        cnt     <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    idle         = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    last         = 1'b0;
    product_next = product + (mplier[0] ? mcand : '0);
    case (state)
      MUL_IDLE: begin
        idle = 1'b1;
        if (start) state_nxt = MUL_RUN;
      end
      MUL_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(DATA_W - 1)) begin
          last      = 1'b1;
          state_nxt = MUL_DONE;
        end
      end
      MUL_DONE: begin
        done      = 1'b1;
        state_nxt = MUL_IDLE;
      end
      default: state_nxt = MUL_IDLE;
    endcase
  end

endmodule

// File: rtl/data_path_param.sv
// K&S data path: IR, PC, register file, flagged ALU. Define DATA_PATH_MUL_EN to add
// the iterative multiplier (busy/done handshake); otherwise MUL decodes/evaluates as no-op.
module data_path_param
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    branch,
  input  logic                    pc_enable,
  input  logic                    ir_enable,
  input  logic                    addr_sel,
  input  logic                    c_sel,
  input  logic                    write_reg_enable,
  input  logic                    flags_reg_enable,
  input  logic [2:0]              operation,
  input  logic                    mul_start,
  output logic                    mul_busy,
  output logic                    mul_done,
  output decoded_instruction_type decoded_instruction,
  output logic                    zero_op,
  output logic                    neg_op,
  output logic                    unsigned_overflow,
  output logic                    signed_overflow,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       data_out,
  input  logic [DATA_W-1:0]       data_in
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int MSB   = DATA_W - 1;

  logic [15:0]        ir;
  logic [ADDR_W-1:0]  pc;
  logic [DATA_W-1:0]  rf [NUM_REGS];

  logic [REG_W-1:0]   idx_a, idx_b, idx_c;
  logic [DATA_W-1:0]  op_a, op_b;
  logic [DATA_W:0]    add_x, sub_x;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_uovf, alu_sovf;

  logic               mul_last;
  logic               mul_hi_nz;
  logic [DATA_W-1:0]  mul_low;
  logic [REG_W-1:0]   mul_c;
  logic               mul_en;
  logic               unused_bits;

  assign idx_a = ir[IR_A_LSB +: REG_W];
  assign idx_b = ir[IR_B_LSB +: REG_W];
  assign idx_c = ir[IR_C_LSB +: REG_W];
  assign op_a  = rf[idx_a];
  assign op_b  = rf[idx_b];

  assign decoded_instruction = decode_opcode(ir[IR_OPC_LSB +: 4], mul_en);
  assign ram_addr            = addr_sel ? pc : ir[ADDR_W-1:0];
  assign data_out            = rf[idx_c];
  assign unused_bits         = ^{ir, data_in};

`ifdef DATA_PATH_MUL_EN
  logic                mul_idle;
  logic [2*DATA_W-1:0] mul_next, mul_product;
  logic                unused_mul;

  assign mul_en = 1'b1;

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (mul_start),
    .a            (op_a),
    .b            (op_b),
    .idle         (mul_idle),
    .busy         (mul_busy),
    .done         (mul_done),
    .last         (mul_last),
    .product_next (mul_next),
    .product      (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst)                        mul_c <= '0;
    else if (mul_start && mul_idle) mul_c <= idx_c;
  end

  assign mul_low    = mul_next[DATA_W-1:0];
  assign mul_hi_nz  = |mul_next[2*DATA_W-1:DATA_W];
  assign unused_mul = ^mul_product[2*DATA_W-1:DATA_W];
`else
  logic unused_mul;

  assign mul_en     = 1'b0;
  assign mul_busy   = 1'b0;
  assign mul_done   = 1'b0;
  assign mul_last   = 1'b0;
  assign mul_low    = '0;
  assign mul_hi_nz  = 1'b0;
  assign mul_c      = '0;
  assign unused_mul = mul_start;
`endif

  // Carry/borrow come from the extra MSB of the widened sum/difference.
  assign add_x = {1'b0, op_a} + {1'b0, op_b};
  assign sub_x = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    alu_res  = '0;
    alu_uovf = 1'b0;
    alu_sovf = 1'b0;
    case (operation)
      ALU_OR:     alu_res = op_a | op_b;
      ALU_ADD: begin
        alu_res  = add_x[DATA_W-1:0];
        alu_uovf = add_x[DATA_W];
        alu_sovf = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        alu_res  = sub_x[DATA_W-1:0];
        alu_uovf = sub_x[DATA_W];
        alu_sovf = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_AND:    alu_res = op_a & op_b;
`ifdef DATA_PATH_MUL_EN
      ALU_MUL:    alu_res = mul_product[DATA_W-1:0];
`endif
      ALU_PASS_A: alu_res = op_a;
      default:    alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc                <= '0;
      ir                <= '0;
      zero_op           <= 1'b0;
      neg_op            <= 1'b0;
      unsigned_overflow <= 1'b0;
      signed_overflow   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      if (ir_enable) ir <= data_in[15:0];
      if (pc_enable) pc <= branch ? ir[ADDR_W-1:0] : pc + 1'b1;
      // The multiplier owns the register file and flags for its whole run.
      if (mul_last) begin
        rf[mul_c]         <= mul_low;
        zero_op           <= (mul_low == '0);
        neg_op            <= mul_low[MSB];
        unsigned_overflow <= mul_hi_nz;
        signed_overflow   <= mul_hi_nz;
      end else if (!mul_busy) begin
        if (write_reg_enable) rf[idx_c] <= c_sel ? alu_res : data_in;
        if (flags_reg_enable) begin
          zero_op           <= (alu_res == '0);
          neg_op            <= alu_res[MSB];
          unsigned_overflow <= alu_uovf;
          signed_overflow   <= alu_sovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_path_param.sv
// Directed + randomized bench for data_path_param against an arithmetic reference model.
`timescale 1ns/1ps
module tb_data_path_param;
  import k_and_s_pkg::*;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 4;
`ifdef DATA_PATH_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic write_reg_enable, flags_reg_enable, mul_start;
  logic [2:0] operation;
  logic mul_busy, mul_done, zero_op, neg_op, unsigned_overflow, signed_overflow;
  decoded_instruction_type decoded_instruction;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] data_out, data_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_r [NUM_REGS];
  logic [15:0] m_ir;
  int          m_pc, m_left, m_mc;
  bit          m_z, m_n, m_u, m_s, m_done;
  longint      m_ma, m_mb;

  data_path_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .addr_sel(addr_sel), .c_sel(c_sel), .write_reg_enable(write_reg_enable),
    .flags_reg_enable(flags_reg_enable), .operation(operation), .mul_start(mul_start),
    .mul_busy(mul_busy), .mul_done(mul_done), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .ram_addr(ram_addr), .data_out(data_out),
    .data_in(data_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected $finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic decoded_instruction_type exp_dec(input logic [3:0] opc);
    case (opc)
      4'h1: return I_LOAD;    4'h2: return I_STORE;  4'h3: return I_MOVE;
      4'h4: return I_ADD;     4'h5: return I_SUB;    4'h6: return I_AND;
      4'h7: return I_OR;      4'h8: return I_BRANCH; 4'h9: return I_BZERO;
      4'hA: return I_BNEG;    4'hB: return I_BOV;    4'hC: return I_BNOV;
      4'hD: return I_HALT;    4'hE: return MUL_EN ? I_MUL : I_NOP;
      default: return I_NOP;
    endcase
  endfunction

  function automatic bit out_of_s16(input int v);
    return (v > 32767) || (v < -32768);
  endfunction

  // Next-state of the architectural model from current inputs.
  task automatic model_step();
    int a, b, c, ua, ub, sa, sb, full;
    logic [15:0] res;
    bit u, s, busy_now;
    longint p;
    if (rst) begin
      foreach (m_r[i]) m_r[i] = '0;
      m_ir = '0; m_pc = 0; m_left = 0; m_done = 0;
      m_z = 0; m_n = 0; m_u = 0; m_s = 0;
      return;
    end
    c  = int'(m_ir[11:8]) % NUM_REGS;
    a  = int'(m_ir[7:4]) % NUM_REGS;
    b  = int'(m_ir[3:0]) % NUM_REGS;
    ua = int'(m_r[a]);
    ub = int'(m_r[b]);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    u = 0; s = 0;
    case (operation)
      3'd0: full = ua | ub;
      3'd1: begin full = ua + ub; u = full > 65535; s = out_of_s16(sa + sb); end
      3'd2: begin full = ua - ub; u = ua < ub;      s = out_of_s16(sa - sb); end
      3'd3: full = ua & ub;
      3'd5: full = ua;
      default: full = 0;
    endcase
    res = full[15:0];
    busy_now = m_left > 0;
    if (m_done) m_done = 0;
    else if (busy_now) begin
      m_left--;
      if (m_left == 0) begin
        p = m_ma * m_mb;
        m_r[m_mc] = p[15:0];
        m_z = (p[15:0] == 16'h0); m_n = p[15];
        m_u = (p >> 16) != 0;     m_s = m_u;
        m_done = 1;
      end
    end else if (mul_start && MUL_EN) begin
      m_ma = ua; m_mb = ub; m_mc = c; m_left = DATA_W;
    end
    if (!busy_now) begin
      if (write_reg_enable) m_r[c] = c_sel ? res : data_in;
      if (flags_reg_enable) begin
        m_z = (res == 16'h0); m_n = res[15]; m_u = u; m_s = s;
      end
    end
    if (pc_enable) m_pc = branch ? int'(m_ir) % (1 << ADDR_W) : (m_pc + 1) % (1 << ADDR_W);
    if (ir_enable) m_ir = data_in;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    branch = 0; pc_enable = 0; ir_enable = 0; addr_sel = 0; c_sel = 0;
    write_reg_enable = 0; flags_reg_enable = 0; mul_start = 0; operation = 3'd0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  32'(data_out), 32'(m_r[int'(m_ir[11:8]) % NUM_REGS]));
    chk({tag, ".flags"}, 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}),
        32'({m_z, m_n, m_u, m_s}));
    chk({tag, ".addr"},  32'(ram_addr), addr_sel ? 32'(m_pc) : 32'(int'(m_ir) % (1 << ADDR_W)));
    chk({tag, ".dec"},   32'(decoded_instruction), 32'(exp_dec(m_ir[15:12])));
    chk({tag, ".busy"},  32'(mul_busy), 32'(m_left > 0));
    chk({tag, ".done"},  32'(mul_done), 32'(m_done));
  endtask

  task automatic set_ir(input logic [15:0] v);
    ir_enable = 1; data_in = v; tick(); ir_enable = 0;
  endtask

  task automatic load_reg(input int k, input logic [15:0] v);
    set_ir({4'h1, 4'(k), 8'h00});
    write_reg_enable = 1; c_sel = 0; data_in = v; tick(); write_reg_enable = 0;
  endtask

  task automatic peek_reg(input string tag, input int k, input logic [15:0] exp);
    set_ir({4'h0, 4'(k), 8'h00});
    chk(tag, 32'(data_out), 32'(exp));
  endtask

  task automatic alu_exec(input logic [15:0] instr, input logic [2:0] op);
    set_ir(instr);
    operation = op; c_sel = 1; write_reg_enable = 1; flags_reg_enable = 1;
    tick();
    idle_inputs();
  endtask

  int busy_cnt, done_at, done_seen;

  initial begin
    idle_inputs();
    data_in = '0;
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    addr_sel = 1;
    chk("rst.pc", 32'(ram_addr), 32'd0);
    chk("rst.busy", 32'(mul_busy), 32'd0);
    chk("rst.flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'd0);
    addr_sel = 0;
    chk("rst.ir_addr", 32'(ram_addr), 32'd0);
    chk("rst.dec", 32'(decoded_instruction), 32'(I_NOP));
    for (int k = 0; k < NUM_REGS; k++) peek_reg($sformatf("rst.r%0d", k), k, 16'h0000);

    // ADD signed overflow
    load_reg(1, 16'h7FFF);
    load_reg(2, 16'h0001);
    alu_exec(16'h4012, 3'b001);
    chk("add.r0", 32'(data_out), 32'h8000);
    chk("add.flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b0101);
    check_all("add");

    // SUB borrow
    load_reg(1, 16'h0003);
    load_reg(2, 16'h0005);
    alu_exec(16'h5012, 3'b010);
    chk("sub.r0", 32'(data_out), 32'hFFFE);
    chk("sub.flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b0110);
    check_all("sub");

    // PC branch and wrap
    set_ir(16'h801F);
    pc_enable = 1; branch = 1; tick();
    addr_sel = 1;
    chk("br.pc31", 32'(ram_addr), 32'd31);
    branch = 0; tick();
    chk("br.wrap", 32'(ram_addr), 32'd0);
    pc_enable = 0;
    set_ir(16'h8011);
    pc_enable = 1; branch = 1; tick();
    pc_enable = 0; branch = 0;
    chk("br.pc17", 32'(ram_addr), 32'd17);
    chk("br.dec", 32'(decoded_instruction), 32'(I_BRANCH));
    check_all("br");
    idle_inputs();

`ifdef DATA_PATH_MUL_EN
    // Multiply with high half overflow
    load_reg(1, 16'h0100);
    load_reg(2, 16'h0100);
    set_ir(16'hE012);
    chk("mul.dec", 32'(decoded_instruction), 32'(I_MUL));
    mul_start = 1; tick(); mul_start = 0;
    busy_cnt = mul_busy ? 1 : 0;
    done_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check_all("mul.run");
      if (mul_busy) busy_cnt++;
      if (mul_done && done_at < 0) done_at = k;
      if (done_at >= 0 && k > done_at + 1) break;
    end
    chk("mul.busy_cycles", 32'(busy_cnt), 32'd16);
    chk("mul.done_at", 32'(done_at), 32'd16);
    chk("mul.r0", 32'(data_out), 32'h0000);
    chk("mul.flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b1011);

    // Reset mid-multiply
    load_reg(1, 16'h0003);
    load_reg(2, 16'h0005);
    set_ir(16'hE012);
    mul_start = 1; tick(); mul_start = 0;
    for (int k = 0; k < 7; k++) tick();
    chk("mrst.busy_before", 32'(mul_busy), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("mrst.busy", 32'(mul_busy), 32'd0);
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (mul_done) done_seen++;
    end
    chk("mrst.no_done", 32'(done_seen), 32'd0);
    peek_reg("mrst.r0", 0, 16'h0000);
`else
    // Multiplier absent: op 100 yields zero, start ignored, opcode E is NOP
    load_reg(1, 16'h0123);
    load_reg(2, 16'h0456);
    alu_exec(16'h4012, 3'b100);
    chk("nomul.r0", 32'(data_out), 32'h0000);
    chk("nomul.flags", 32'({zero_op, neg_op, unsigned_overflow, signed_overflow}), 32'b1000);
    mul_start = 1; tick(); mul_start = 0;
    chk("nomul.busy", 32'(mul_busy), 32'd0);
    tick();
    chk("nomul.done", 32'(mul_done), 32'd0);
    set_ir(16'hE012);
    chk("nomul.dec", 32'(decoded_instruction), 32'(I_NOP));
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      ir_enable        = ($urandom_range(0, 3) == 0);
      pc_enable        = $urandom_range(0, 1);
      branch           = $urandom_range(0, 1);
      addr_sel         = $urandom_range(0, 1);
      c_sel            = $urandom_range(0, 1);
      write_reg_enable = $urandom_range(0, 1);
      flags_reg_enable = $urandom_range(0, 1);
      mul_start        = MUL_EN && ($urandom_range(0, 15) == 0);
      operation        = 3'($urandom_range(0, 7));
      if (MUL_EN && operation == 3'b100) operation = 3'b001;
      data_in          = 16'($urandom);
      tick();
      check_all("rand");
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
